// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared types and constants for the OTTER fetch stage
package otter_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] OTTER_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory read channel (request + response)
interface instr_fetch_if;
  import otter_pkg::*;

  logic [XLEN-1:0] addr;
  logic            rd_valid;
  logic            rd_ready;
  logic            rsp_valid;
  logic [XLEN-1:0] data;

  modport master (output addr, rd_valid, input rd_ready, rsp_valid, data);
  modport slave  (input addr, rd_valid, output rd_ready, rsp_valid, data);
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch with flush and timeout
module instr_fetch
  import otter_pkg::*;
#(
  parameter int              WAIT_MAX  = 255,
  parameter logic [XLEN-1:0] NOP_INSTR = OTTER_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            fetch_req,
  input  logic            flush,
  instr_fetch_if.master   imem,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] ir_pc,
  output logic            ir_valid,
  output logic            fetch_busy,
  output logic            misalign_err,
  output logic            fetch_fault
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WAIT_MAX);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic            rd_valid_q, rd_valid_n;
  logic [XLEN-1:0] ir_n, ir_pc_n;
  logic            ir_valid_n, mis_n, fault_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            drop, drop_n;
  logic            timeout;

  assign imem.addr     = addr_q;
  assign imem.rd_valid = rd_valid_q;
  assign fetch_busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      rd_valid_q   <= 1'b0;
      ir           <= NOP_INSTR;
      ir_pc        <= '0;
      ir_valid     <= 1'b0;
      misalign_err <= 1'b0;
      fetch_fault  <= 1'b0;
      cnt          <= '0;
      drop         <= 1'b0;
    end else begin
      state        <= state_n;
      addr_q       <= addr_n;
      rd_valid_q   <= rd_valid_n;
      ir           <= ir_n;
      ir_pc        <= ir_pc_n;
      ir_valid     <= ir_valid_n;
      misalign_err <= mis_n;
      fetch_fault  <= fault_n;
      cnt          <= cnt_n;
      drop         <= drop_n;
    end
  end

  // This edge is the WAIT_MAX-th one spent with the fetch outstanding.
  assign timeout = (cnt >= CNT_LAST);

  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    rd_valid_n = rd_valid_q;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    mis_n      = 1'b0;
    fault_n    = 1'b0;
    cnt_n      = cnt;
    drop_n     = drop;

    if (state != IDLE) begin
      cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end
    if (flush) begin
      ir_n       = NOP_INSTR;
      ir_valid_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!flush && fetch_req) begin
          ir_valid_n = 1'b0;
          if (pc_addr[1:0] != 2'b00) begin
            mis_n = 1'b1;
          end else begin
            addr_n     = pc_addr;
            rd_valid_n = 1'b1;
            cnt_n      = '0;
            drop_n     = 1'b0;
            state_n    = REQ;
          end
        end
      end
      REQ: begin
        if (timeout) begin
          fault_n    = 1'b1;
          rd_valid_n = 1'b0;
          ir_valid_n = 1'b0;
          state_n    = IDLE;
        end else begin
          if (flush) drop_n = 1'b1;
          // A flushed request still completes its handshake; its response is then discarded.
          if (imem.rd_ready) begin
            rd_valid_n = 1'b0;
            state_n    = (drop || flush) ? DROP : WAIT;
          end
        end
      end
      WAIT: begin
        if (imem.rsp_valid) begin
          state_n = IDLE;
          if (!flush) begin
            ir_n       = imem.data;
            ir_pc_n    = addr_q;
            ir_valid_n = 1'b1;
          end
        end else if (timeout) begin
          fault_n    = 1'b1;
          ir_valid_n = 1'b0;
          state_n    = IDLE;
        end else if (flush) begin
          state_n = DROP;
        end
      end
      DROP: begin
        if (imem.rsp_valid) begin
          state_n = IDLE;
        end else if (timeout) begin
          fault_n    = 1'b1;
          ir_valid_n = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the OTTER core. It sits directly downstream of the program counter register: it takes the PC value, issues a single-outstanding read to instruction memory over a valid/ready handshake, and captures the returned word into the instruction register (IR) for decode. It also handles misaligned PCs, branch-redirect flushes of in-flight fetches, and memory timeouts, so the control FSM only sees a clean IR_VALID/FETCH_BUSY view.

## Interface
- WAIT_MAX, 255: cycles a request may stay outstanding (REQ+WAIT) before it is abandoned; range 2..65535.
- NOP_INSTR, 32'h0000_0013: IR reset/flush value (addi x0,x0,0).

- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- PC_ADDR  in  32  current PC, from PC DOUT.
- FETCH_REQ  in  1  control FSM: fetch at PC_ADDR; sampled only in IDLE.
- FLUSH  in  1  branch redirect: invalidate IR and any in-flight fetch.
- IMEM_ADDR  out  32  registered request address.
- IMEM_RD_VALID  out  1  request valid; held until accepted.
- IMEM_RD_READY  in  1  memory accepts request when high with VALID.
- IMEM_RSP_VALID  in  1  response data valid, one cycle.
- IMEM_DATA  in  32  response instruction word.
- IR  out  32  captured instruction.
- IR_PC  out  32  address IR was fetched from.
- IR_VALID  out  1  IR holds a live instruction.
- FETCH_BUSY  out  1  high whenever state != IDLE.
- MISALIGN_ERR  out  1  one-cycle pulse: FETCH_REQ with PC_ADDR[1:0] != 0.
- FETCH_FAULT  out  1  one-cycle pulse: request timed out.

## Operation
- States: IDLE, REQ (request presented, not accepted), WAIT (accepted, awaiting response), DROP (in-flight fetch being discarded).
- IDLE: FETCH_REQ with aligned PC_ADDR -> latch IMEM_ADDR=PC_ADDR, clear IR_VALID, go REQ. Misaligned -> MISALIGN_ERR pulse, no bus request, stay IDLE, IR_VALID cleared.
- REQ: IMEM_RD_VALID=1, IMEM_ADDR stable. VALID&READY -> WAIT. Requests are never withdrawn.
- WAIT: IMEM_RSP_VALID -> IR=IMEM_DATA, IR_PC=IMEM_ADDR, IR_VALID=1, go IDLE.
- FLUSH: IR=NOP_INSTR, IR_VALID=0. In IDLE stays IDLE; in REQ sets drop flag (request completes acceptance, then -> DROP); in WAIT -> DROP. DROP: response consumed and discarded, -> IDLE, IR unchanged.
- Timeout counter: 0 on entry to REQ, +1 per cycle in REQ/WAIT/DROP; reaching WAIT_MAX -> FETCH_FAULT pulse, IMEM_RD_VALID drops, -> IDLE, IR_VALID=0. Counter saturates, never wraps.
- IMEM_RSP_VALID in IDLE or REQ is ignored (late/stray response).
- FETCH_REQ outside IDLE is ignored; control waits on FETCH_BUSY=0.

## Timing
- Reset values: state IDLE, IMEM_ADDR=0, IMEM_RD_VALID=0, IR=NOP_INSTR, IR_PC=0, IR_VALID=0, FETCH_BUSY=0, MISALIGN_ERR=0, FETCH_FAULT=0, counter=0, drop flag=0.
- All outputs registered. FETCH_REQ sampled at edge k -> IMEM_RD_VALID and FETCH_BUSY high from k+1.
- Minimum latency: accepted at edge a, RSP_VALID at earliest edge a+1, IR/IR_VALID updated at that edge; FETCH_BUSY low same edge. Zero-wait memory: FETCH_REQ to IR_VALID = 3 edges.
- FLUSH and FETCH_REQ same cycle in IDLE: FLUSH wins, no request.
- FLUSH and IMEM_RSP_VALID same cycle in WAIT: response discarded, -> IDLE, IR=NOP_INSTR, IR_VALID=0.
- Timeout and response same cycle: response wins, no FAULT.
- RESET mid-operation: immediate return to reset values; memory side must tolerate the dropped request.

## Structure
- otter_pkg: fetch_state_t enum (IDLE, REQ, WAIT, DROP), OTTER_NOP constant (default for NOP_INSTR), XLEN=32.
- Single module, no sub-modules; timeout counter inline, width $clog2(WAIT_MAX+1).

## Test plan
- Zero-wait fetch: PC_ADDR=0x100, FETCH_REQ, READY=1, RSP next cycle DATA=0x00500093 -> IR=0x00500093, IR_PC=0x100, IR_VALID=1, 3 edges after request.
- Backpressure: READY low 4 cycles -> IMEM_RD_VALID held, IMEM_ADDR stable 0x104 throughout; single acceptance.
- Misaligned: PC_ADDR=0x102, FETCH_REQ -> MISALIGN_ERR one cycle, IMEM_RD_VALID never asserted, IR_VALID=0.
- Flush in WAIT: accept 0x200, FLUSH, RSP DATA=0xDEADBEEF 2 cycles later -> IR=0x00000013, IR_VALID=0, FETCH_BUSY low after response; next fetch of 0x300 succeeds.
- Timeout: WAIT_MAX=8, READY never high -> FETCH_FAULT pulse at 8th cycle, IDLE, later stray RSP_VALID ignored.
- Async reset asserted mid-WAIT between edges -> all outputs reset values immediately, IR=0x00000013.
